// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter step scheduler.
package counter_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/ud_counter_core.sv
// Up/down counter that wraps modulo 2^WIDTH and flags each wrap-around step.
module ud_counter_core
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntOne = {{(WIDTH-1){1'b0}}, 1'b1};

  // Step the count when enabled; wrap is high the cycle after a wrapping step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        if (ud == DIR_UP) begin
          count <= count + CntOne;
          wrap  <= (count == CntMax);
        end else begin
          count <= count - CntOne;
          wrap  <= (count == '0);
        end
      end
    end
  end

endmodule

// File: rtl/counter_step_scheduler.sv
// Round-robin scheduler that lends one up/down counter to two requesters for
// a requested number of steps each, then reports completion.
module counter_step_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STEPS_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_dir,
  input  logic [STEPS_W-1:0] req_steps0,
  input  logic [STEPS_W-1:0] req_steps1,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic               cnt_en,
  output logic               cnt_ud,
  output logic [WIDTH-1:0]   count,
  output logic               wrap
);

  localparam logic [STEPS_W-1:0] StepOne = {{(STEPS_W-1){1'b0}}, 1'b1};

  sched_state_t       state;
  logic               last_winner;
  logic               id_q;
  logic [STEPS_W-1:0] remaining;

  logic               winner;
  logic               win_dir;
  logic [STEPS_W-1:0] win_steps;

  // Pick the winner: a lone request wins, a tie goes to the one that did not win last.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_winner;
    end else begin
      winner = req[1];
    end
    win_dir   = req_dir[winner];
    win_steps = winner ? req_steps1 : req_steps0;
  end

  // Scheduler FSM with registered grant, status and counter controls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      id_q        <= 1'b0;
      remaining   <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      cnt_en      <= 1'b0;
      cnt_ud      <= 1'b0;
    end else begin
      gnt <= '0;
      unique case (state)
        IDLE: begin
          done    <= 1'b0;
          done_id <= 1'b0;
          if (|req) begin
            last_winner <= winner;
            id_q        <= winner;
            remaining   <= win_steps;
            gnt         <= winner ? 2'b10 : 2'b01;
            busy        <= 1'b1;
            if (win_steps != '0) begin
              state  <= RUN;
              cnt_en <= 1'b1;
              cnt_ud <= win_dir;
            end else begin
              // Zero steps: grant and done share the same cycle.
              state   <= DONE;
              done    <= 1'b1;
              done_id <= winner;
            end
          end
        end
        RUN: begin
          remaining <= remaining - StepOne;
          if (remaining == StepOne) begin
            state   <= DONE;
            cnt_en  <= 1'b0;
            cnt_ud  <= 1'b0;
            done    <= 1'b1;
            done_id <= id_q;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          done_id <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          cnt_en <= 1'b0;
          cnt_ud <= 1'b0;
        end
      endcase
    end
  end

  ud_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .ud   (cnt_ud),
    .count(count),
    .wrap (wrap)
  );

endmodule
